tetris_pixel_pipe: RTL

- Next-generation pixel compositor for the Tetris VGA path; sits between the VGA controller (DrawX/DrawY) and the DAC RGB outputs.
- Playfield is stored as a cell-indexed colour RAM (one 3-bit colour index per cell) instead of a per-pixel bit array.
- Draws NUM_BLOCKS active-piece blocks in cell coordinates, plus the border.
- Adds a 2-stage registered pipeline and a row-clear flash animation FSM with busy/done handshake.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/tetris_pixel_pipe_clear_flash_fsm.sv | 72 +++++++
 rtl/tetris_pixel_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared colour types, palette and flash FSM states for the Tetris pixel path.
// Used by tetris_pixel_pipe and clear_flash_fsm.
package tetris_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BLACK     = '{8'h00, 8'h00, 8'h00};
  localparam rgb_t WHITE     = '{8'hff, 8'hff, 8'hff};
  localparam rgb_t GRID_GREY = '{8'h30, 8'h30, 8'h30};

  localparam rgb_t palette [0:7] = '{
    '{8'h00, 8'h00, 8'h00},
    '{8'h00, 8'hf0, 8'hf0},
    '{8'h00, 8'h00, 8'hf0},
    '{8'hf0, 8'ha0, 8'h00},
    '{8'hf0, 8'hf0, 8'h00},
    '{8'h00, 8'hf0, 8'h00},
    '{8'ha0, 8'h00, 8'hf0},
    '{8'hf0, 8'h00, 8'h00}
  };

  typedef enum logic [1:0] {
    IDLE,
    FLASH,
    DONE
  } flash_state_t;

endpackage

// File: rtl/tetris_pixel_pipe_clear_flash_fsm.sv
// Row-clear flash animation: latches the row mask, counts frames,
// and reports whether a given row is currently lit.
module clear_flash_fsm
  import tetris_pkg::*;
#(
  parameter int ROWS         = 20,
  parameter int FLASH_FRAMES = 24,
  localparam int ROW_W = $clog2(ROWS),
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic             clear_start,
  input  logic [ROWS-1:0]  clear_rows,
  input  logic [ROW_W-1:0] row,
  output logic             busy,
  output logic             clear_done,
  output logic             flash_lit
);

  flash_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROWS-1:0]  mask, mask_n;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mask  <= mask_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mask_n     = mask;
    busy       = 1'b0;
    clear_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_start) begin
          mask_n  = clear_rows;
          cnt_n   = '0;
          state_n = FLASH;
        end
      end
      FLASH: begin
        busy = 1'b1;
        if (frame_start) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(FLASH_FRAMES - 1))
            state_n = DONE;
        end
      end
      DONE: begin
        clear_done = 1'b1;
        mask_n     = '0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Phase flips every 4 frames so lit rows blink on/off.
  assign flash_lit = (state == FLASH) && cnt[2] && mask[row];

endmodule

// File: rtl/tetris_pixel_pipe.sv
// Two-stage pixel compositor: active piece, row flash, stored cells, border.
// Optional macro GRID_LINES_EN draws grey cell grid lines on empty cells.
module tetris_pixel_pipe
  import tetris_pkg::*;
#(
  parameter int NUM_BLOCKS   = 4,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CELL_PX      = 20,
  parameter int FIELD_X0     = 200,
  parameter int FIELD_Y0     = 0,
  parameter int BORDER_PX    = 20,
  parameter int FLASH_FRAMES = 24,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int ADDR_W = $clog2(ROWS * COLS)
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  input  logic                             frame_start,
  input  logic [NUM_BLOCKS-1:0][COL_W-1:0] block_x,
  input  logic [NUM_BLOCKS-1:0][ROW_W-1:0] block_y,
  input  logic                             piece_valid,
  input  logic [2:0]                       piece_color,
  output logic [ADDR_W-1:0]                cell_rd_addr,
  input  logic [2:0]                       cell_rd_data,
  input  logic                             clear_start,
  input  logic [ROWS-1:0]                  clear_rows,
  output logic                             busy,
  output logic                             clear_done,
  output logic                             field_hit,
  output logic [7:0]                       Red,
  output logic [7:0]                       Green,
  output logic [7:0]                       Blue
);

  localparam int X_SPAN = COLS * CELL_PX;
  localparam int Y_SPAN = ROWS * CELL_PX;

  logic [9:0]       dx, dy, bdx;
  logic             in_field, border;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Offsets wrap when left of/above the origin, so one compare bounds both sides.
  assign dx  = DrawX - 10'(FIELD_X0);
  assign dy  = DrawY - 10'(FIELD_Y0);
  assign bdx = DrawX - 10'(FIELD_X0 - BORDER_PX);

  assign in_field = (dx < 10'(X_SPAN)) && (dy < 10'(Y_SPAN));
  assign border   = (bdx < 10'(X_SPAN + 2 * BORDER_PX))
                 && (dy < 10'(Y_SPAN + BORDER_PX))
                 && !in_field;

  assign col = COL_W'(dx / 10'(CELL_PX));
  assign row = ROW_W'(dy / 10'(CELL_PX));

  assign cell_rd_addr = in_field
    ? ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)
    : '0;

  logic             s1_in, s1_border;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;

`ifdef GRID_LINES_EN
  logic grid, s1_grid;
  assign grid = in_field
    && ((dx % 10'(CELL_PX) == '0) || (dy % 10'(CELL_PX) == '0));

  always_ff @(posedge Clk) begin
    if (Reset) s1_grid <= 1'b0;
    else       s1_grid <= grid;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_in     <= 1'b0;
      s1_border <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
    end else begin
      s1_in     <= in_field;
      s1_border <= border;
      s1_col    <= col;
      s1_row    <= row;
    end
  end

  logic flash_lit;

  clear_flash_fsm #(
    .ROWS         (ROWS),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .clear_start (clear_start),
    .clear_rows  (clear_rows),
    .row         (s1_row),
    .busy        (busy),
    .clear_done  (clear_done),
    .flash_lit   (flash_lit)
  );

  logic blk_hit, hit;
  rgb_t pix;

  always_comb begin
    blk_hit = 1'b0;
    for (int i = 0; i < NUM_BLOCKS; i++)
      if (block_x[i] == s1_col && block_y[i] == s1_row)
        blk_hit = 1'b1;
    blk_hit = blk_hit && piece_valid && s1_in;
  end

  always_comb begin
    pix = BLACK;
    hit = 1'b0;
    if (blk_hit)
      pix = palette[piece_color];
    else if (s1_in && flash_lit)
      pix = WHITE;
    else if (s1_in && cell_rd_data != 3'd0) begin
      pix = palette[cell_rd_data];
      hit = 1'b1;
    end else if (s1_border)
      pix = WHITE;
`ifdef GRID_LINES_EN
    else if (s1_grid)
      pix = GRID_GREY;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      field_hit <= 1'b0;
    end else begin
      Red       <= pix.r;
      Green     <= pix.g;
      Blue      <= pix.b;
      field_hit <= hit;
    end
  end

endmodule
